// File: rtl/jump_request_handler_if.sv
// Button/window inputs and jump outputs shared between the jump handler and sprite logic.
interface jump_request_handler_if #(
    parameter int HEIGHT_W = 8
);
    logic                can_jump;
    logic                jump_btn;
    logic [HEIGHT_W-1:0] jump_height;
    logic                airborne;
    logic                jump_start;
    logic                landed;

    modport master (
        output can_jump, jump_btn,
        input  jump_height, airborne, jump_start, landed
    );

    modport slave (
        input  can_jump, jump_btn,
        output jump_height, airborne, jump_start, landed
    );
endinterface

// File: rtl/jump_request_handler.sv
// Synchronizes the jump button, holds a pending request until can_jump opens, and runs
// the rise/fall height sequence. Optional mid-air double jump: define DOUBLE_JUMP_EN.
module jump_request_handler #(
    parameter int RISE_STEPS   = 8,
    parameter int STEP_CYCLES  = 4,
    parameter int JUMP_STEP    = 2,
    parameter int HEIGHT_W     = 8,
    parameter int PEND_TIMEOUT = 16
) (
    input  logic                   proc_clk,
    input  logic                   reset,
    jump_request_handler_if.slave  jr
);
    // state | meaning
    // IDLE  | on the ground, waiting for a request and an open window
    // RISE  | ascending one JUMP_STEP every STEP_CYCLES cycles
    // FALL  | descending until height reaches 0
    typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int RW = $clog2(RISE_STEPS + 1);
    localparam int PW = (PEND_TIMEOUT > 1) ? $clog2(PEND_TIMEOUT) : 1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0]       PEND_LOAD = PW'(PEND_TIMEOUT - 1);
    localparam logic [RW-1:0]       RISE_LAST = RW'(RISE_STEPS);
    localparam logic [HEIGHT_W-1:0] STEP_H    = HEIGHT_W'(JUMP_STEP);

    state_t              state, state_n;
    logic                sync1, sync2, prev;
    logic                btn_edge;
    logic [SW-1:0]       step_cnt, step_n;
    logic [RW-1:0]       rise_cnt, rise_n, rise_inc;
    logic [HEIGHT_W-1:0] height, height_n, height_up;
    logic [HEIGHT_W:0]   height_sum;
    logic                start_q, start_n;
    logic                landed_q, landed_n;
    logic                pending, pending_n;
    logic [PW-1:0]       pend_cnt, pend_cnt_n;
    logic                step_tc;
`ifdef DOUBLE_JUMP_EN
    logic                token, token_n;
`endif

    assign btn_edge   = sync2 & ~prev;
    assign step_tc    = (step_cnt == STEP_LAST);
    assign rise_inc   = rise_cnt + 1'b1;
    assign height_sum = {1'b0, height} + {1'b0, STEP_H};
    assign height_up  = height_sum[HEIGHT_W] ? {HEIGHT_W{1'b1}} : height_sum[HEIGHT_W-1:0];

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            state    <= IDLE;
            step_cnt <= '0;
            rise_cnt <= '0;
            height   <= '0;
            start_q  <= 1'b0;
            landed_q <= 1'b0;
            pending  <= 1'b0;
            pend_cnt <= '0;
`ifdef DOUBLE_JUMP_EN
            token    <= 1'b1;
`endif
        end else begin
            sync1    <= jr.jump_btn;
            sync2    <= sync1;
            prev     <= sync2;
            state    <= state_n;
            step_cnt <= step_n;
            rise_cnt <= rise_n;
            height   <= height_n;
            start_q  <= start_n;
            landed_q <= landed_n;
            pending  <= pending_n;
            pend_cnt <= pend_cnt_n;
`ifdef DOUBLE_JUMP_EN
            token    <= token_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        step_n     = step_cnt;
        rise_n     = rise_cnt;
        height_n   = height;
        start_n    = 1'b0;
        landed_n   = 1'b0;
        pending_n  = pending;
        pend_cnt_n = pend_cnt;
`ifdef DOUBLE_JUMP_EN
        token_n    = token;
`endif
        // Pending lifetime: load PEND_TIMEOUT-1, drop the request after terminal count
        if (pending) begin
            if (pend_cnt == '0) pending_n = 1'b0;
            else                pend_cnt_n = pend_cnt - 1'b1;
        end

        case (state)
            IDLE: begin
                if ((pending | btn_edge) & jr.can_jump) begin
                    state_n   = RISE;
                    step_n    = '0;
                    rise_n    = '0;
                    start_n   = 1'b1;
                    pending_n = 1'b0;
                end else if (btn_edge) begin
                    pending_n  = 1'b1;
                    pend_cnt_n = PEND_LOAD;
                end
            end
            RISE: begin
                if (step_tc) begin
                    step_n   = '0;
                    height_n = height_up;
                    rise_n   = rise_inc;
                    if (rise_inc == RISE_LAST) begin
                        state_n = FALL;
                        rise_n  = '0;
                    end
                end else begin
                    step_n = step_cnt + 1'b1;
                end
            end
            FALL: begin
                if (step_tc) begin
                    step_n = '0;
                    if (height <= STEP_H) begin
                        height_n = '0;
                        state_n  = IDLE;
                        landed_n = 1'b1;
`ifdef DOUBLE_JUMP_EN
                        token_n  = 1'b1;
`endif
                    end else begin
                        height_n = height - STEP_H;
                    end
                end else begin
                    step_n = step_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef DOUBLE_JUMP_EN
        // A mid-air restart wins over any step or landing scheduled for the same cycle
        if ((state != IDLE) && btn_edge && jr.can_jump && token) begin
            state_n  = RISE;
            step_n   = '0;
            rise_n   = '0;
            height_n = height;
            start_n  = 1'b1;
            landed_n = 1'b0;
            token_n  = 1'b0;
        end
`endif
    end

    assign jr.jump_height = height;
    assign jr.airborne    = (state != IDLE);
    assign jr.jump_start  = start_q;
    assign jr.landed      = landed_q;
endmodule

// File: doc/jump_request_handler.md
Name: jump_request_handler

Overview:
Consumer side of the jump-enable window. The block takes the raw player jump button and synchronizes and edge-detects it. It holds the request pending until the can_jump window is open, then runs a rise/fall state machine that drives the sprite's vertical jump offset. It sits between the button input and the sprite position logic, clocked by proc_clk.

Parameters:
RISE_STEPS, 8, number of height increments in the ascent
STEP_CYCLES, 4, proc_clk cycles per height step (must be >= 1)
JUMP_STEP, 2, pixels added or removed per step
HEIGHT_W, 8, width of jump_height
PEND_TIMEOUT, 16, cycles an unserved request stays pending

Ports:
proc_clk  in  1  processor clock; the only clock
reset  in  1  asynchronous, active-high reset
can_jump  in  1  jump-enable window from the jump-window generator
jump_btn  in  1  raw button, asynchronous to proc_clk
jump_height  out  HEIGHT_W  current vertical offset above ground, in pixels
airborne  out  1  high in RISE and FALL
jump_start  out  1  one-cycle pulse when a jump is accepted
landed  out  1  one-cycle pulse when height returns to 0

Behaviour:
- Reset (async, active-high): state=IDLE; synchronizer, pending flag, counters and all outputs = 0. Reset mid-jump immediately forces jump_height=0 and airborne=0, with no landed pulse.
- Synchronizer: two-flop sync of jump_btn, then a registered previous value. btn_edge = sync2 & ~prev. A rising edge on jump_btn appears as btn_edge 2–3 cycles later.
- Pending request:
  - Set on btn_edge while in IDLE.
  - Cleared on accept, or when the pending counter reaches PEND_TIMEOUT (pending flag is high for exactly PEND_TIMEOUT cycles).
  - A new btn_edge while pending restarts the timeout.
- States:
  - IDLE: accept when (pending | btn_edge) & can_jump. The same-cycle edge with can_jump high is accepted without waiting. On accept: next state RISE, step_cnt=0, rise_cnt=0, jump_start=1 for one cycle (registered, asserted the cycle the state becomes RISE), pending cleared.
  - RISE:
    - step_cnt counts 0..STEP_CYCLES-1.
    - At terminal count: jump_height += JUMP_STEP, saturating at 2^HEIGHT_W-1, and rise_cnt++.
    - When rise_cnt reaches RISE_STEPS, go to FALL.
  - FALL:
    - At each step terminal count: if jump_height <= JUMP_STEP, then jump_height=0, state=IDLE, and landed=1 for one cycle (registered).
    - Otherwise jump_height -= JUMP_STEP.
- btn_edge while airborne is ignored and does not set pending (without the optional feature below).
- can_jump is sampled only in IDLE; it has no effect in RISE or FALL.
- Defaults give: peak height 16; ascent 32 cycles; descent 32 cycles. The cycle the state becomes IDLE, jump_height is 0, and a new accept is possible on the next cycle.
- No arithmetic wraps: increments saturate at the maximum and decrements floor at 0.

Optional Feature:
DOUBLE_JUMP_EN:
- Defined: in RISE or FALL, a btn_edge with can_jump=1, while the double-jump token is unused, does the following:
  - restarts RISE from the current jump_height;
  - sets rise_cnt=0 and step_cnt=0;
  - pulses jump_start;
  - consumes the token.
  The token is restored when landed pulses or on reset.
- Undefined: airborne button edges are ignored, and no token logic exists.

Test Plan:
- Reset then idle: reset high 3 cycles, release, no button for 50 cycles -> jump_height=0, airborne=0, jump_start=0, landed=0 throughout.
- Basic jump: can_jump held 1, jump_btn rises -> jump_start pulse within 4 cycles; jump_height climbs 2,4,...,16 every 4 cycles; then falls to 0; landed pulses once, 64 cycles after jump_start.
- Window gating: can_jump=0, press button, raise can_jump 10 cycles later -> accept on first cycle can_jump=1, jump_start pulses. Repeat with can_jump raised 20 cycles later -> request expired, no jump.
- Airborne press ignored: press at height 8 during RISE -> no extra jump_start, normal landing. With DOUBLE_JUMP_EN, the same press -> jump_start pulse and peak height 24. A second airborne press -> ignored.
- Async reset mid-fall: assert reset at jump_height=10 -> next sample shows jump_height=0, airborne=0, landed=0. After release, a new press gives a normal jump.
- Back-to-back: button held through landing, then re-pressed 1 cycle after landed with can_jump=1 -> new jump_start; jump_height starts from 0.
